// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shift window, producer for conv_unit.
// Optional feature: define CONV_ZERO_PAD_EN for zero-padded windows on every pixel (adds FLUSH).
module conv_window_gen #(
    parameter int WIDTH = 9,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a00,
    output logic [WIDTH-1:0] a01,
    output logic [WIDTH-1:0] a02,
    output logic [WIDTH-1:0] a10,
    output logic [WIDTH-1:0] a11,
    output logic [WIDTH-1:0] a12,
    output logic [WIDTH-1:0] a20,
    output logic [WIDTH-1:0] a21,
    output logic [WIDTH-1:0] a22,
    output logic             frame_done
);
    localparam int AW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             out_valid_q, out_valid_d;
    logic             last_q, last_d;
    logic             frame_done_q, frame_done_d;
    logic [WIDTH-1:0] win_q [3][3];
    logic [WIDTH-1:0] win_d [3][3];
    logic [WIDTH-1:0] a_q [3][3];
    logic [WIDTH-1:0] a_d [3][3];

    logic [WIDTH-1:0] line1_mem [IMG_W];
    logic [WIDTH-1:0] line2_mem [IMG_W];

    logic             can_load, in_ready_int, in_fire, out_fire;
    logic             step, emit, is_last;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] new_pix;

`ifdef CONV_ZERO_PAD_EN
    localparam int FW = $clog2(IMG_W + 2);
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [AW-1:0] cc_q, cc_d;
    logic [RW-1:0] cr_q, cr_d;
    logic          flush_step, last_pix;
`endif

    always_comb begin
        can_load     = !out_valid_q || out_ready;
        in_ready_int = (state_q != FLUSH) && can_load;
        in_fire      = in_valid && in_ready_int;
        out_fire     = out_valid_q && out_ready;
`ifdef CONV_ZERO_PAD_EN
        // FLUSH replays IMG_W+1 virtual pixels past the frame end; their taps are all masked.
        flush_step = (state_q == FLUSH) && can_load && (fcnt_q <= FW'(IMG_W));
        last_pix   = in_fire && (row_q == ROW_LAST) && (col_q == COL_LAST);
        step       = in_fire || flush_step;
        if (state_q == FLUSH) begin
            rd_addr = (fcnt_q >= FW'(IMG_W)) ? '0 : fcnt_q[AW-1:0];
            new_pix = '0;
        end else begin
            rd_addr = col_q;
            new_pix = in_data;
        end
        emit    = flush_step ||
                  (in_fire && ((row_q >= RW'(2)) || ((row_q == RW'(1)) && (col_q != '0))));
        is_last = (cr_q == ROW_LAST) && (cc_q == COL_LAST);
`else
        step    = in_fire;
        rd_addr = col_q;
        new_pix = in_data;
        emit    = in_fire && (row_q >= RW'(2)) && (col_q >= AW'(2));
        is_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
`endif
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = line2_mem[rd_addr];
            win_d[1][2] = line1_mem[rd_addr];
            win_d[2][2] = new_pix;
        end
    end

    // The raw shift window keeps unmasked taps; masking only touches the output copy.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                a_d[r][c] = a_q[r][c];
                if (emit) begin
`ifdef CONV_ZERO_PAD_EN
                    if (((r == 0) && (cr_q == '0)) || ((r == 2) && (cr_q == ROW_LAST)) ||
                        ((c == 0) && (cc_q == '0)) || ((c == 2) && (cc_q == COL_LAST))) begin
                        a_d[r][c] = '0;
                    end else begin
                        a_d[r][c] = win_d[r][c];
                    end
`else
                    a_d[r][c] = win_d[r][c];
`endif
                end
            end
        end
    end

    always_comb begin
        out_valid_d  = emit || (out_valid_q && !out_ready);
        last_d       = emit ? is_last : last_q;
        frame_done_d = out_fire && last_q;
        col_d        = col_q;
        row_d        = row_q;
        if (in_fire) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + AW'(1);
            end
        end
        state_d = state_q;
        case (state_q)
            FILL, RUN: begin
`ifdef CONV_ZERO_PAD_EN
                if (last_pix) begin
                    state_d = FLUSH;
                end else if (emit) begin
                    state_d = RUN;
                end
`else
                if (emit) begin
                    state_d = is_last ? FILL : RUN;
                end
`endif
            end
`ifdef CONV_ZERO_PAD_EN
            FLUSH: begin
                if (out_fire && last_q) begin
                    state_d = FILL;
                end
            end
`endif
            default: state_d = FILL;
        endcase
`ifdef CONV_ZERO_PAD_EN
        cc_d = cc_q;
        cr_d = cr_q;
        if (emit) begin
            if (cc_q == COL_LAST) begin
                cc_d = '0;
                cr_d = (cr_q == ROW_LAST) ? '0 : cr_q + RW'(1);
            end else begin
                cc_d = cc_q + AW'(1);
            end
        end
        fcnt_d = fcnt_q;
        if (flush_step) begin
            fcnt_d = fcnt_q + FW'(1);
        end
        if ((state_q == FLUSH) && out_fire && last_q) begin
            fcnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                    a_q[r][c]   <= '0;
                end
            end
`ifdef CONV_ZERO_PAD_EN
            fcnt_q <= '0;
            cc_q   <= '0;
            cr_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= win_d[r][c];
                    a_q[r][c]   <= a_d[r][c];
                end
            end
`ifdef CONV_ZERO_PAD_EN
            fcnt_q <= fcnt_d;
            cc_q   <= cc_d;
            cr_q   <= cr_d;
`endif
        end
    end

    // Line buffers are never cleared; rows they hold from an earlier frame are never emitted.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            line2_mem[col_q] <= line1_mem[col_q];
            line1_mem[col_q] <= in_data;
        end
    end

    assign in_ready   = in_ready_int;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign a00 = a_q[0][0];
    assign a01 = a_q[0][1];
    assign a02 = a_q[0][2];
    assign a10 = a_q[1][0];
    assign a11 = a_q[1][1];
    assign a12 = a_q[1][2];
    assign a20 = a_q[2][0];
    assign a21 = a_q[2][1];
    assign a22 = a_q[2][2];
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 4x4 image; windows are derived directly from pixel coordinates.
module tb_conv_window_gen;
    localparam int WIDTH = 9;
    localparam int IW    = 4;
    localparam int IH    = 4;
    localparam int NPIX  = IW * IH;
`ifdef CONV_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
    logic             frame_done;
    logic [9*WIDTH-1:0] cur;

    always #5 clk = ~clk;

    conv_window_gen #(.WIDTH(WIDTH), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .a00(a00), .a01(a01), .a02(a02),
        .a10(a10), .a11(a11), .a12(a12),
        .a20(a20), .a21(a21), .a22(a22),
        .frame_done(frame_done)
    );

    assign cur = {a00, a01, a02, a10, a11, a12, a20, a21, a22};

    typedef struct {
        logic [9*WIDTH-1:0] win;
        bit                 last;
        bit                 flush;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fd_seen = 0;
    int   ready_mode = 0;
    int   pix_buf[64];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int px(input int base, input int r, input int c);
        if (r < 0 || r >= IH || c < 0 || c >= IW) return 0;
        return pix_buf[base + r * IW + c];
    endfunction

    // Expected windows of one frame, in emission order; only those whose trigger pixel index < limit.
    task automatic push_frame(input int base, input int limit);
        exp_t             e;
        int               idx;
        bit               ok;
        logic [WIDTH-1:0] v;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if (PAD) begin
                    ok  = 1'b1;
                    idx = r * IW + c + IW + 1;
                end else begin
                    ok  = (r >= 1) && (r <= IH - 2) && (c >= 1) && (c <= IW - 2);
                    idx = (r + 1) * IW + (c + 1);
                end
                if (ok && idx < limit) begin
                    e.win = '0;
                    for (int i = -1; i <= 1; i++) begin
                        for (int j = -1; j <= 1; j++) begin
                            v = WIDTH'(px(base, r + i, c + j));
                            e.win = {e.win[8*WIDTH-1:0], v};
                        end
                    end
                    e.last  = PAD ? (r == IH - 1 && c == IW - 1) : (r == IH - 2 && c == IW - 2);
                    e.flush = PAD && (idx >= NPIX);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic drive(input int base, input int n, input int bub);
        int i = 0;
        int guard = 0;
        bit tog = 1'b0;
        while (i < n && guard < 4000) begin
            @(posedge clk);
            #2;
            if ((bub == 1 && tog) || (bub == 2 && $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = WIDTH'(pix_buf[base + i]);
            end
            tog = !tog;
            #1;
            if (in_valid && in_ready) i++;
            guard++;
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        chk("pixels_accepted", i, n);
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || out_valid) && g < 400) begin
            @(posedge clk);
            g++;
        end
        chk("drain_left", sb.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_window", cur, 0);
        chk("rst_frame_done", frame_done, 0);
    endtask

    task automatic fill_seq(input int base, input int start);
        for (int i = 0; i < NPIX; i++) pix_buf[base + i] = start + i;
    endtask

    task automatic fill_rand(input int base);
        for (int i = 0; i < NPIX; i++) pix_buf[base + i] = int'($urandom_range(0, 511));
    endtask

    initial begin
        int rcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 9) < 7);
                2: begin
                    rcnt++;
                    out_ready = ((rcnt % 6) >= 3);
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    initial begin
        logic [9*WIDTH-1:0] held;
        bit   stall;
        bit   exp_fd;
        exp_t e;
        stall  = 1'b0;
        exp_fd = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall  = 1'b0;
                exp_fd = 1'b0;
            end else begin
                chk("frame_done", frame_done, exp_fd);
                if (frame_done) fd_seen++;
                exp_fd = 1'b0;
                if (stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_window", cur, held);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_window: got %0h, expected no window", cur);
                    end else begin
                        e = sb.pop_front();
                        chk("window", cur, e.win);
                        if (e.last) exp_fd = 1'b1;
                        if (e.flush) chk("flush_in_ready", in_ready, 0);
                    end
                end
                stall = out_valid && !out_ready;
                if (stall) begin
                    chk("stall_in_ready", in_ready, 0);
                    held = cur;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // basic frame, handshakes held high
        ready_mode = 0;
        fill_seq(0, 0);
        push_frame(0, 1000);
        drive(0, NPIX, 0);
        drain();

        // backpressure: out_ready low 3 of every 6 cycles
        ready_mode = 2;
        push_frame(0, 1000);
        drive(0, NPIX, 0);
        drain();

        // input bubbles every other cycle with random backpressure
        ready_mode = 1;
        push_frame(0, 1000);
        drive(0, NPIX, 1);
        drain();

        // back-to-back frames 0..15 then 100..115
        ready_mode = 0;
        fill_seq(16, 100);
        push_frame(0, 1000);
        push_frame(16, 1000);
        drive(0, 2 * NPIX, 0);
        drain();

        // two random frames with random bubbles and backpressure
        ready_mode = 1;
        fill_rand(0);
        fill_rand(16);
        push_frame(0, 1000);
        push_frame(16, 1000);
        drive(0, 2 * NPIX, 2);
        drain();

        // reset after 7 pixels, then a fresh basic frame
        ready_mode = 0;
        fill_seq(0, 0);
        push_frame(0, 7);
        drive(0, 7, 0);
        repeat (3) @(posedge clk);
        chk("partial_left", sb.size(), 0);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset();
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        push_frame(0, 1000);
        drive(0, NPIX, 0);
        drain();

        chk("frame_done_count", fd_seen, 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
